duty_ramp8: RTL

- Upstream feeder for the 8-bit PWM generator: accepts target duty commands and slews the PWM `duty` input toward the target at a bounded rate (soft-start / soft-stop).
- Updates `duty` only at PWM period boundaries so no period is ever truncated or glitched.
- Keeps its own 8-bit free-running period counter in lockstep with the PWM counter; both reset from the same rst_n and clk, and both count every clk.
- Provides a latched emergency kill that forces duty to 0.

---
 rtl/pwm_pkg.sv | 32 +++
 rtl/period_sync8.sv | 54 +++++
 rtl/duty_ramp8.sv | 103 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Desc     : Shared types and period constants for the 8-bit PWM datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP_UP = 2'd1,
      RAMP_DN = 2'd2,
      KILL    = 2'd3
   } ramp_state_t;

   localparam logic [7:0] PWM_PER_LAST = 8'hFF;
   localparam logic [7:0] UPD_SLOT     = 8'hFE;

   function automatic logic [7:0] clamp8(input logic [7:0] v,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      logic [7:0] r;
      r = v;
      if (v < lo) r = lo;
      if (v > hi) r = hi;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/period_sync8.sv
// ============================================================================
// Module   : period_sync8
// Desc     : Free-running period counter and ramp-rate divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module period_sync8
   import pwm_pkg::*;
#(
   parameter int unsigned PER_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic div_clr_i,
   output logic period_tick_o,
   output logic step_en_o
);

   localparam logic [7:0] DIV_LAST = 8'(PER_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic [7:0] div_q;
   logic [7:0] div_d;
   logic       tick;

   assign tick          = (cnt_q == UPD_SLOT);
   assign period_tick_o = tick;
   assign step_en_o     = tick && (div_q == DIV_LAST);
   assign cnt_d         = cnt_q + 8'd1;

   always_comb begin
      div_d = div_q;
      if (div_clr_i) begin
         div_d = 8'd0;
      end else if (tick) begin
         div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         div_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/duty_ramp8.sv
// ============================================================================
// Module   : duty_ramp8
// Desc     : Slew-limited duty feeder for the 8-bit PWM with latched kill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module duty_ramp8
   import pwm_pkg::*;
#(
   parameter logic [7:0]  STEP     = 8'd1,
   parameter int unsigned PER_DIV  = 4,
   parameter logic [7:0]  DUTY_MIN = 8'h00,
   parameter logic [7:0]  DUTY_MAX = 8'hF0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tgt_duty,
   input  logic       tgt_vld,
   output logic       tgt_rdy,
   input  logic       kill,
   input  logic       kill_clr,
   output logic [7:0] duty,
   output logic       at_target,
   output logic       ramping,
   output logic       period_tick
);

   ramp_state_t state_q;
   ramp_state_t state_d;
   logic [7:0]  duty_q;
   logic [7:0]  duty_d;
   logic [7:0]  target_q;
   logic [7:0]  target_d;
   logic        step_en;
   logic        xfer;
   logic [8:0]  gap_up;
   logic [8:0]  gap_dn;
   logic [8:0]  step9;

   period_sync8 #(
      .PER_DIV (PER_DIV)
   ) u_sync (
      .clk           (clk),
      .rst_n         (rst_n),
      .div_clr_i     (kill),
      .period_tick_o (period_tick),
      .step_en_o     (step_en)
   );

   assign tgt_rdy   = (state_q != KILL);
   assign xfer      = tgt_vld && tgt_rdy;
   assign gap_up    = {1'b0, target_q} - {1'b0, duty_q};
   assign gap_dn    = {1'b0, duty_q} - {1'b0, target_q};
   assign step9     = {1'b0, STEP};
   assign duty      = duty_q;
   assign at_target = (duty_q == target_q) && (state_q != KILL);
   assign ramping   = (state_q == RAMP_UP) || (state_q == RAMP_DN);

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      if (kill) begin
         state_d  = KILL;
         duty_d   = 8'd0;
         target_d = 8'd0;
      end else if (state_q == KILL) begin
         if (kill_clr) state_d = IDLE;
      end else begin
         if (xfer) target_d = clamp8(tgt_duty, DUTY_MIN, DUTY_MAX);

         if (target_q > duty_q)      state_d = RAMP_UP;
         else if (target_q < duty_q) state_d = RAMP_DN;
         else                        state_d = IDLE;

         // Direction comes from the registered state, so guard against a
         // target that crossed duty one clk before the state caught up.
         if (step_en) begin
            if ((state_q == RAMP_UP) && (target_q > duty_q)) begin
               duty_d = (gap_up <= step9) ? target_q : duty_q + STEP;
            end else if ((state_q == RAMP_DN) && (target_q < duty_q)) begin
               duty_d = (gap_dn <= step9) ? target_q : duty_q - STEP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         duty_q   <= 8'd0;
         target_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
      end
   end

endmodule

`default_nettype wire
